// File: rtl/arm_defs_pkg.sv
// arm_defs: shared ARM pipeline constants (register index width, PC index, ALU commands)
package arm_defs;
    localparam int REG_AW = 4;
    localparam int PC_IDX = 15;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b1100;
    localparam logic [3:0] EXE_TST = 4'b1110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;
endpackage

// File: rtl/id_ex_stage_reg_operand_bypass.sv
// operand_bypass: substitutes write-back data for one operand when the indices match (never for PC)
module operand_bypass
    import arm_defs::PC_IDX;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [DATA_W-1:0] val
);
    assign val = (used && wb_en && wb_dest == src && src != REG_AW'(PC_IDX)) ? wb_value : reg_val;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with flush, freeze, bubble and write-back bypass
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = arm_defs::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [REG_AW-1:0] src_1,
    input  logic [REG_AW-1:0] src_2,
    input  logic              src_2_used,
    input  logic [DATA_W-1:0] reg_1,
    input  logic [DATA_W-1:0] reg_2,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        status_in,
    input  logic              wb_en_wb,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic [REG_AW-1:0] dest,
    output logic [3:0]        exe_cmd,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en,
    output logic              b,
    output logic              s,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        status,
    output logic [REG_AW-1:0] src_1_out,
    output logic [REG_AW-1:0] src_2_out
);
    logic              src_2_used_q;
    logic [DATA_W-1:0] byp_1;
    logic [DATA_W-1:0] byp_2;

    // While frozen the bypass units look at the held slot, otherwise at the incoming instruction
    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_1 (
        .src(freeze ? src_1_out : src_1), .used(freeze ? valid_out : 1'b1),
        .reg_val(freeze ? val_rn : reg_1), .wb_en(wb_en_wb), .wb_dest(wb_dest),
        .wb_value(wb_value), .val(byp_1)
    );
    operand_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_byp_2 (
        .src(freeze ? src_2_out : src_2), .used(freeze ? (valid_out & src_2_used_q) : src_2_used),
        .reg_val(freeze ? val_rm : reg_2), .wb_en(wb_en_wb), .wb_dest(wb_dest),
        .wb_value(wb_value), .val(byp_2)
    );

    // Slot register: reset/flush clear, freeze holds (operands may refresh), otherwise capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0; pc <= '0; val_rn <= '0; val_rm <= '0; dest <= '0; exe_cmd <= '0;
            mem_r_en <= 1'b0; mem_w_en <= 1'b0; wb_en <= 1'b0; b <= 1'b0; s <= 1'b0; imm <= 1'b0;
            shift_operand <= '0; signed_imm_24 <= '0; status <= '0;
            src_1_out <= '0; src_2_out <= '0; src_2_used_q <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0; pc <= '0; val_rn <= '0; val_rm <= '0; dest <= '0; exe_cmd <= '0;
            mem_r_en <= 1'b0; mem_w_en <= 1'b0; wb_en <= 1'b0; b <= 1'b0; s <= 1'b0; imm <= 1'b0;
            shift_operand <= '0; signed_imm_24 <= '0; status <= '0;
            src_1_out <= '0; src_2_out <= '0; src_2_used_q <= 1'b0;
        end else if (freeze) begin
            val_rn <= byp_1;
            val_rm <= byp_2;
        end else begin
            valid_out <= id_valid; pc <= pc_in; val_rn <= byp_1; val_rm <= byp_2;
            dest <= dest_in; exe_cmd <= exe_cmd_in;
            mem_r_en <= mem_r_en_in & id_valid; mem_w_en <= mem_w_en_in & id_valid;
            wb_en <= wb_en_in & id_valid; b <= b_in & id_valid; s <= s_in & id_valid;
            imm <= imm_in; shift_operand <= shift_operand_in; signed_imm_24 <= signed_imm_24_in;
            status <= status_in; src_1_out <= src_1; src_2_out <= src_2; src_2_used_q <= src_2_used;
        end
    end
endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, operand/PC width; REG_AW, default 4, register index width.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous, active-low reset
  freeze  in  1  hazard stall; hold all outputs
  flush  in  1  branch taken; kill incoming slot
  id_valid  in  1  decode stage presents an instruction
  pc_in  in  DATA_W  PC of decoded instruction
  src_1, src_2  in  REG_AW  source register indices
  src_2_used  in  1  instruction reads src_2
  reg_1, reg_2  in  DATA_W  register file read data
  dest_in  in  REG_AW  destination index
  exe_cmd_in  in  4  ALU command
  mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in  in  1 each  control bits
  shift_operand_in  in  12  shifter operand
  signed_imm_24_in  in  24  branch offset
  status_in  in  4  NZCV flags
  wb_en_wb  in  1  write-back stage write enable
  wb_dest  in  REG_AW  write-back destination
  wb_value  in  DATA_W  write-back data
  valid_out  out  1  EX slot holds a live instruction
  pc, val_rn, val_rm, dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, imm, shift_operand, signed_imm_24, status, src_1_out, src_2_out  out  widths as inputs  registered copies

Function
REQ-003 On each rising clk with rst high, freeze low and flush low, the block SHALL capture all *_in fields and set valid_out = id_valid (latency one cycle).
REQ-004 flush SHALL take priority over freeze: valid_out, mem_r_en, mem_w_en, wb_en, b, s SHALL be cleared to 0 next edge; data fields are don't-care but SHALL be cleared to 0.
REQ-005 When id_valid is 0 the control bits mem_r_en, mem_w_en, wb_en, b, s SHALL be captured as 0 (bubble).
REQ-006 With freeze high and flush low, all outputs SHALL hold, except per REQ-008.
REQ-007 Capture bypass: if wb_en_wb and wb_dest == src_1 and src_1 != 15, val_rn SHALL capture wb_value instead of reg_1; same for src_2/val_rm gated additionally by src_2_used.
REQ-008 Held-slot update: while frozen with valid_out = 1, if wb_en_wb and wb_dest equals src_1_out (≠15), val_rn SHALL load wb_value; likewise src_2_out/val_rm when the held instruction used src_2.
REQ-009 A stored used-bit for src_2 SHALL accompany src_2_out to gate REQ-008.
REQ-010 Index 15 (PC) SHALL never be bypassed; reg_1/reg_2 used as supplied.
REQ-011 Status SHALL be captured unchanged; no flag computation here.
REQ-012 Simultaneous flush and wb write SHALL yield the flushed (cleared) result.

Reset
REQ-013 rst low SHALL asynchronously force every output, including valid_out and src_2 used-bit, to 0; release is synchronised by the integrating top.
REQ-014 First edge after rst release SHALL behave per REQ-003..REQ-006.

Structure
REQ-015 exe_cmd encodings, REG_AW, and the PC index constant 15 SHALL live in the shared arm_defs package.
REQ-016 One sub-module, operand_bypass (compare-and-select for one operand, used twice), is natural; all state stays in id_ex_stage_reg.

Verification
REQ-017 Reset mid-stream: rst low during valid instruction -> all outputs 0 immediately, valid_out 0.
REQ-018 Normal capture: id_valid=1, pc_in=0x10, reg_1=5, reg_2=7, wb_en_in=1 -> next edge pc=0x10, val_rn=5, val_rm=7, valid_out=1.
REQ-019 Capture bypass: src_1=3, reg_1=0x3, wb_en_wb=1, wb_dest=3, wb_value=0xAA -> val_rn=0xAA; repeat with src_1=15 -> val_rn=reg_1.
REQ-020 Frozen update: slot holds src_2_out=4 used, freeze=1 two cycles, wb write R4=0x55 in second -> val_rm=0x55, other outputs unchanged.
REQ-021 flush+freeze together with mem_w_en_in=1 -> valid_out=0, mem_w_en=0, wb_en=0 next edge.
REQ-022 Bubble: id_valid=0, wb_en_in=1, mem_r_en_in=1 -> wb_en=0, mem_r_en=0, valid_out=0.
